player_hit_manager: RTL and testbench

Sits directly upstream of the death-animation stage. It detects player/hazard overlap from the OLED pixel stream and tracks remaining lives. On a confirmed hit it issues a one-cycle `player_die` pulse. It then holds off further hits until the downstream reviving flag has risen and fallen again, so the blink period doubles as invulnerability.

---
 rtl/player_hit_manager.sv | 138 +++++++++++++
 tb/tb_player_hit_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_hit_manager.sv
// Player/hazard overlap detector with lives tracking. A confirmed hit pulses
// player_die once, then waits for the downstream revive blink before re-arming.
module player_hit_manager #(
    parameter int START_LIVES   = 3,
    parameter int LIVES_W       = 2,
    parameter int HIT_THRESHOLD = 4,
    parameter int CNT_W         = 13,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic               clk6p25m,
    input  logic               reset,
    input  logic               frame_begin,
    input  logic               player,
    input  logic               hazard,
    input  logic               isReviving,
    input  logic               restart,
    output logic               player_die,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam int                 TMR_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   THRESH     = CNT_W'(HIT_THRESHOLD);
    localparam logic [CNT_W-1:0]   OV_MAX     = '1;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

    typedef enum logic [2:0] {
        ALIVE     = 3'd0,
        DYING     = 3'd1,
        WAIT_ACK  = 3'd2,
        REVIVING  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   ov_r;
    logic [CNT_W-1:0]   ov_s;
    logic [CNT_W-1:0]   ov_cnt_s;
    logic [TMR_W-1:0]   tmr_r;
    logic [TMR_W-1:0]   tmr_s;
    logic [LIVES_W-1:0] lives_r;
    logic [LIVES_W-1:0] lives_s;
    logic               player_die_r;
    logic               game_over_r;
    logic               overlap_s;
    logic               hit_s;
    logic               enter_alive_s;

    assign overlap_s = player & hazard;
    // Evaluation uses the count of the frame that just ended, before the reload.
    assign hit_s     = frame_begin && (ov_r >= THRESH) && (lives_r != '0);

    // Next-state, lives, timeout and overlap-counter logic.
    always_comb begin
        state_s = state_r;
        lives_s = lives_r;
        tmr_s   = tmr_r;

        if (frame_begin) begin
            ov_cnt_s = CNT_W'(overlap_s);
        end else if (overlap_s && (ov_r != OV_MAX)) begin
            ov_cnt_s = ov_r + CNT_W'(1);
        end else begin
            ov_cnt_s = ov_r;
        end

        case (state_r)
            ALIVE: begin
                if (hit_s) begin
                    state_s = DYING;
                    lives_s = lives_r - LIVES_W'(1);
                end else begin
                    state_s = ALIVE;
                end
            end
            DYING: begin
                tmr_s = '0;
                if (lives_r == '0) begin
                    state_s = GAME_OVER;
                end else begin
                    state_s = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (isReviving) begin
                    state_s = REVIVING;
                end else if (tmr_r == TMR_LAST) begin
                    state_s = ALIVE;
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            REVIVING: begin
                if (!isReviving) begin
                    state_s = ALIVE;
                end else begin
                    state_s = REVIVING;
                end
            end
            GAME_OVER: begin
                state_s = GAME_OVER;
            end
            default: begin
                state_s = ALIVE;
            end
        endcase

        // Overlap accumulated while invulnerable must not carry into ALIVE.
        enter_alive_s = (state_s == ALIVE) && (state_r != ALIVE);
        ov_s          = enter_alive_s ? '0 : ov_cnt_s;
    end

    // State and registered outputs; restart behaves exactly like reset.
    always_ff @(posedge clk6p25m) begin
        if (reset || restart) begin
            state_r      <= ALIVE;
            ov_r         <= '0;
            tmr_r        <= '0;
            lives_r      <= LIVES_INIT;
            player_die_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            ov_r         <= ov_s;
            tmr_r        <= tmr_s;
            lives_r      <= lives_s;
            player_die_r <= (state_s == DYING);
            game_over_r  <= (state_s == GAME_OVER);
        end
    end

    assign player_die = player_die_r;
    assign lives      = lives_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_player_hit_manager.sv
// Self-checking bench for player_hit_manager: directed vector table, corner
// sequences, and randomized traffic against an event-level reference model.
module tb_player_hit_manager;

    localparam int START_LIVES   = 3;
    localparam int LIVES_W       = 2;
    localparam int HIT_THRESHOLD = 4;
    localparam int CNT_W         = 13;
    localparam int ACK_TIMEOUT   = 16;
    localparam int OV_MAX        = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_begin = 1'b0;
    logic               player = 1'b0;
    logic               hazard = 1'b0;
    logic               isReviving = 1'b0;
    logic               restart = 1'b0;
    logic               player_die;
    logic [LIVES_W-1:0] lives;
    logic               game_over;

    int n_checks = 0;
    int n_fail   = 0;

    player_hit_manager #(
        .START_LIVES  (START_LIVES),
        .LIVES_W      (LIVES_W),
        .HIT_THRESHOLD(HIT_THRESHOLD),
        .CNT_W        (CNT_W),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk6p25m   (clk),
        .reset      (reset),
        .frame_begin(frame_begin),
        .player     (player),
        .hazard     (hazard),
        .isReviving (isReviving),
        .restart    (restart),
        .player_die (player_die),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: lives, overlap count and the invulnerability phases as flags.
    int m_lives     = START_LIVES;
    int m_ov        = 0;
    bit m_pulse     = 1'b0;
    bit m_over      = 1'b0;
    bit m_waiting   = 1'b0;
    int m_wait_cnt  = 0;
    bit m_reviving  = 1'b0;

    task automatic model_step(input bit fb, input bit ovl, input bit rev, input bit clr);
        int n_ov;
        bit to_alive;
        if (clr) begin
            m_lives = START_LIVES; m_ov = 0; m_pulse = 0; m_over = 0;
            m_waiting = 0; m_wait_cnt = 0; m_reviving = 0;
        end else begin
            to_alive = 0;
            if (fb) n_ov = ovl ? 1 : 0;
            else    n_ov = (m_ov + int'(ovl) > OV_MAX) ? OV_MAX : m_ov + int'(ovl);
            if (m_pulse) begin
                m_pulse = 0;
                if (m_lives == 0) m_over = 1;
                else begin m_waiting = 1; m_wait_cnt = 0; end
            end else if (m_waiting) begin
                if (rev) begin m_waiting = 0; m_reviving = 1; end
                else begin
                    m_wait_cnt++;
                    if (m_wait_cnt == ACK_TIMEOUT) begin m_waiting = 0; to_alive = 1; end
                end
            end else if (m_reviving) begin
                if (!rev) begin m_reviving = 0; to_alive = 1; end
            end else if (!m_over && fb && m_ov >= HIT_THRESHOLD) begin
                m_pulse = 1;
                m_lives--;
            end
            m_ov = to_alive ? 0 : n_ov;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit fb, input bit p, input bit h, input bit rev,
                       input bit rs, input bit rst);
        frame_begin = fb; player = p; hazard = h; isReviving = rev;
        restart = rs; reset = rst;
        model_step(fb, p & h, rev, rs | rst);
        @(posedge clk);
        #1;
        check("player_die", int'(player_die), int'(m_pulse));
        check("lives", int'(lives), m_lives);
        check("game_over", int'(game_over), int'(m_over));
    endtask

    task automatic hit_frame();
        for (int i = 0; i < HIT_THRESHOLD; i++) cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit fb; bit ph; bit rev; bit rs; bit rst;
        bit e_die; int e_lives; bit e_over;
    } vec_t;

    function automatic vec_t v(bit fb, bit ph, bit rev, bit rs, bit rst,
                               bit e_die, int e_lives, bit e_over);
        vec_t r;
        r.fb = fb; r.ph = ph; r.rev = rev; r.rs = rs; r.rst = rst;
        r.e_die = e_die; r.e_lives = e_lives; r.e_over = e_over;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        int pulses;
        int frame_pos;
        int frame_len;
        int rev_hold;
        bit rev_cur;
        bit fb;

        // Hit with 4 overlaps, ack handshake, 3-overlap miss, 4-overlap hit, restart on a hit.
        tbl.push_back(v(0,0,0,0,1, 0,3,0));
        tbl.push_back(v(1,0,0,0,0, 0,3,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,0,0, 0,3,0));
        tbl.push_back(v(1,0,0,0,0, 1,2,0));
        tbl.push_back(v(0,0,0,0,0, 0,2,0));
        tbl.push_back(v(0,0,1,0,0, 0,2,0));
        tbl.push_back(v(0,1,1,0,0, 0,2,0));
        tbl.push_back(v(0,0,0,0,0, 0,2,0));
        tbl.push_back(v(1,0,0,0,0, 0,2,0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,0,0,0, 0,2,0));
        tbl.push_back(v(1,0,0,0,0, 0,2,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,0,0, 0,2,0));
        tbl.push_back(v(1,0,0,0,0, 1,1,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0));
        tbl.push_back(v(0,0,1,0,0, 0,1,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,0,0, 0,1,0));
        tbl.push_back(v(1,1,0,1,0, 0,3,0));
        tbl.push_back(v(1,0,0,0,0, 0,3,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].fb, tbl[i].ph, tbl[i].ph, tbl[i].rev, tbl[i].rs, tbl[i].rst);
            check("tbl_die", int'(player_die), int'(tbl[i].e_die));
            check("tbl_lives", int'(lives), tbl[i].e_lives);
            check("tbl_over", int'(game_over), int'(tbl[i].e_over));
        end

        // Invulnerable for 1000 cycles of overlapping frames while reviving.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        hit_frame();
        cyc(0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc((i % 8) == 7, 1, 1, 1, 0, 0);
            pulses += int'(player_die);
        end
        check("no_pulse_while_reviving", pulses, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("ov_cleared_on_alive", int'(player_die), 0);
        hit_frame();
        check("second_hit_pulse", int'(player_die), 1);
        check("second_hit_lives", int'(lives), 1);

        // Lose every life; game_over lags the last pulse by one cycle and is sticky.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < START_LIVES; k++) begin
            hit_frame();
            if (k < START_LIVES - 1) begin
                cyc(0, 0, 0, 0, 0, 0);
                cyc(0, 0, 0, 1, 0, 0);
                cyc(0, 0, 0, 0, 0, 0);
            end
        end
        check("final_pulse", int'(player_die), 1);
        check("final_lives", int'(lives), 0);
        check("over_not_yet", int'(game_over), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("over_rises", int'(game_over), 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 6) == 5, 1, 1, 0, 0, 0);
            pulses += int'(player_die);
        end
        check("no_pulse_game_over", pulses, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("restart_lives", int'(lives), START_LIVES);
        check("restart_over", int'(game_over), 0);

        // Ack timeout: exactly ACK_TIMEOUT cycles in WAIT_ACK, then ALIVE with ov cleared.
        cyc(1, 0, 0, 0, 0, 0);
        hit_frame();
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("timeout_boundary_no_hit", int'(player_die), 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("timeout_then_hit", int'(player_die), 1);

        // Reset in the middle of REVIVING.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 1);
        check("reset_die", int'(player_die), 0);
        check("reset_lives", int'(lives), START_LIVES);
        check("reset_over", int'(game_over), 0);

        // Randomized traffic with a plausible downstream reviving responder.
        frame_pos = 0;
        frame_len = 8;
        rev_hold  = 0;
        for (int i = 0; i < 4000; i++) begin
            fb = (frame_pos == 0);
            frame_pos++;
            if (frame_pos >= frame_len) begin
                frame_pos = 0;
                frame_len = $urandom_range(5, 12);
            end
            rev_cur = (rev_hold > 0);
            if (rev_hold > 0) rev_hold--;
            if (player_die && ($urandom_range(0, 3) != 0)) rev_hold = $urandom_range(1, 20);
            if ($urandom_range(0, 15) == 0) rev_cur = ~rev_cur;
            cyc(fb, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, rev_cur,
                $urandom_range(0, 299) == 0, $urandom_range(0, 599) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
